// File: rtl/ls155_tdm_demux_pkg.sv
// Shared types for the LS155-style TDM demultiplexer: the channel-select type,
// the channel count and the FSM state encoding.
package ls_mux_pkg;

   localparam int NCH = 4;

   typedef logic [1:0] chan_t;

   typedef enum logic {
      HUNT,
      COLLECT
   } demux_state_t;

endpackage

// File: rtl/ls155_tdm_demux_if.sv
// Bus between the upstream 4:1 mux side and the demux. The master drives the samples;
// the slave (the demux) drives the select lines, strobes and the frame outputs.
interface ls155_tdm_demux_if #(
   parameter int W = 1
);
   import ls_mux_pkg::*;

   logic             g_n;
   logic [W-1:0]     din;
   logic             din_valid;
   logic             sync;
   chan_t            sel;
   logic [NCH-1:0]   strb_n;
   logic [NCH*W-1:0] y;
   logic             frame_valid;
   logic             err;

   modport master (
      output g_n, din, din_valid, sync,
      input  sel, strb_n, y, frame_valid, err
   );

   modport slave (
      input  g_n, din, din_valid, sync,
      output sel, strb_n, y, frame_valid, err
   );

endinterface

// File: rtl/ls155_tdm_demux_decoder.sv
// Combinational 2-to-4 decoder with an active-low enable and active-low
// one-hot outputs, behaving like one half of a 74LS155.
module ls_chan_decoder
   import ls_mux_pkg::*;
(
   input  chan_t          sel,
   input  logic           en_n,
   output logic [NCH-1:0] out_n
);

   always_comb begin
      out_n = '1;
      if (!en_n) begin
         out_n[sel] = 1'b0;
      end
   end

endmodule

// File: rtl/ls155_tdm_demux.sv
// De-interleaves a 4-channel time-multiplexed sample stream into a frame register,
// steering the upstream mux through sel and reporting framing errors.
module ls155_tdm_demux
   import ls_mux_pkg::*;
#(
   parameter int W = 1
) (
   input  logic              clk,
   input  logic              rst,
   ls155_tdm_demux_if.slave  bus
);

   demux_state_t        state_q, state_d;
   chan_t               sel_q, sel_d;
   logic [2:0][W-1:0]   shadow_q, shadow_d;
   logic [NCH*W-1:0]    y_q, y_d;
   logic                frame_valid_q, frame_valid_d;
   logic                err_q, err_d;
   logic                accept;
   logic [NCH-1:0]      strb_n;

   assign accept = ~bus.g_n & bus.din_valid;

   ls_chan_decoder u_decoder (
      .sel   (sel_q),
      .en_n  (bus.g_n | ~bus.din_valid),
      .out_n (strb_n)
   );

   // A sync while expecting ch1..ch3 drops the partial frame but is still a valid ch0,
   // so the sequencer resynchronises without passing through HUNT.
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      shadow_d      = shadow_q;
      y_d           = y_q;
      frame_valid_d = 1'b0;
      err_d         = 1'b0;

      if (accept) begin
         case (state_q)
            HUNT: begin
               if (bus.sync) begin
                  shadow_d[0] = bus.din;
                  sel_d       = 2'd1;
                  state_d     = COLLECT;
               end
            end
            COLLECT: begin
               if (bus.sync) begin
                  if (sel_q != 2'd0) begin
                     err_d = 1'b1;
                  end
                  shadow_d[0] = bus.din;
                  sel_d       = 2'd1;
               end else begin
                  case (sel_q)
                     2'd0: begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                     end
                     2'd1: begin
                        shadow_d[1] = bus.din;
                        sel_d       = 2'd2;
                     end
                     2'd2: begin
                        shadow_d[2] = bus.din;
                        sel_d       = 2'd3;
                     end
                     default: begin
                        y_d           = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
                        frame_valid_d = 1'b1;
                        sel_d         = 2'd0;
                     end
                  endcase
               end
            end
            default: begin
               state_d = HUNT;
               sel_d   = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= HUNT;
         sel_q         <= 2'd0;
         shadow_q      <= '0;
         y_q           <= '0;
         frame_valid_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         shadow_q      <= shadow_d;
         y_q           <= y_d;
         frame_valid_q <= frame_valid_d;
         err_q         <= err_d;
      end
   end

   assign bus.sel         = sel_q;
   assign bus.strb_n      = strb_n;
   assign bus.y           = y_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_ls155_tdm_demux.sv
// Self-checking bench for ls155_tdm_demux: fixed vector table, hand-written corner
// sequences and randomized traffic compared against a queue-based frame model.
module tb_ls155_tdm_demux;
   import ls_mux_pkg::*;

   localparam int W = 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ls155_tdm_demux_if #(.W(W)) bus ();

   ls155_tdm_demux #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a locked flag plus the samples of the frame gathered so far.
   bit               m_locked;
   bit [W-1:0]       m_part[$];
   logic [4*W-1:0]   m_y;
   bit               m_fv;
   bit               m_err;

   logic [3:0] strb_seen;

   typedef struct {
      logic       g_n;
      logic       din;
      logic       dv;
      logic       sync;
      logic [3:0] strb;
      logic [1:0] sel;
      logic [3:0] y;
      logic       fv;
      logic       err;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_sel();
      return m_locked ? m_part.size() : 0;
   endfunction

   function automatic logic [3:0] model_strb(input logic g, input logic v);
      logic [3:0] s;
      s = 4'hF;
      if (!g && v) s[model_sel()] = 1'b0;
      return s;
   endfunction

   task automatic model_accept(input bit [W-1:0] d, input bit s);
      if (!m_locked) begin
         if (s) begin
            m_part   = {d};
            m_locked = 1'b1;
         end
      end else if (s) begin
         if (m_part.size() != 0) m_err = 1'b1;
         m_part = {d};
      end else if (m_part.size() == 0) begin
         m_err    = 1'b1;
         m_locked = 1'b0;
      end else begin
         m_part.push_back(d);
         if (m_part.size() == 4) begin
            m_y  = {m_part[3], m_part[2], m_part[1], m_part[0]};
            m_fv = 1'b1;
            m_part.delete();
         end
      end
   endtask

   task automatic model_reset();
      m_locked = 1'b0;
      m_part.delete();
      m_y   = '0;
      m_fv  = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic applyStimulus(input logic g, input logic [W-1:0] d, input logic v, input logic s);
      @(negedge clk);
      bus.g_n       = g;
      bus.din       = d;
      bus.din_valid = v;
      bus.sync      = s;
      #1;
      strb_seen = bus.strb_n;
      @(posedge clk);
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (!g && v) model_accept(d, s);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      check({tag, "_sel"}, 32'(bus.sel), 32'(model_sel()));
      check({tag, "_y"}, 32'(bus.y), 32'(m_y));
      check({tag, "_fv"}, 32'(bus.frame_valid), 32'(m_fv));
      check({tag, "_err"}, 32'(bus.err), 32'(m_err));
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst           = 1'b1;
      bus.g_n       = 1'b0;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      bus.sync      = 1'b0;
      repeat (n) @(posedge clk);
      model_reset();
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_strb;
      logic       g, v, s;
      logic [W-1:0] d;
      int         fv_count;

      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hE, 2'd1, 4'h0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hD, 2'd2, 4'h0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hB, 2'd3, 4'h0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 2'd0, 4'hD, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hE, 2'd1, 4'hD, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hD, 2'd2, 4'hD, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hB, 2'd1, 4'hD, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hD, 2'd2, 4'hD, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 2'd3, 4'hD, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 2'd0, 4'h9, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 2'd0, 4'h9, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 2'd0, 4'h9, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 2'd0, 4'h9, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hE, 2'd0, 4'h9, 1'b0, 1'b0};

      model_reset();
      do_reset(2);
      check("reset_y", 32'(bus.y), 32'h0);
      check("reset_sel", 32'(bus.sel), 32'h0);
      check("reset_fv", 32'(bus.frame_valid), 32'h0);
      check("reset_err", 32'(bus.err), 32'h0);
      check("reset_strb", 32'(bus.strb_n), 32'hF);

      $display("[TB] vector table");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].g_n, vecs[i].din, vecs[i].dv, vecs[i].sync);
         check($sformatf("vec%0d_strb", i), 32'(strb_seen), 32'(vecs[i].strb));
         check($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vecs[i].sel));
         check($sformatf("vec%0d_y", i), 32'(bus.y), 32'(vecs[i].y));
         check($sformatf("vec%0d_fv", i), 32'(bus.frame_valid), 32'(vecs[i].fv));
         check($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vecs[i].err));
      end

      $display("[TB] back-to-back frames");
      do_reset(1);
      fv_count = 0;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] bits;
         bits = 8'b0011_0110;
         applyStimulus(1'b0, bits[i], 1'b1, (i % 4) == 0);
         if (bus.frame_valid) fv_count++;
         check($sformatf("b2b%0d_fv", i), 32'(bus.frame_valid), 32'((i == 3) || (i == 7)));
         check($sformatf("b2b%0d_y", i), 32'(bus.y), (i < 3) ? 32'h0 : (i < 7) ? 32'h6 : 32'h3);
         checkOutput("b2b_model");
      end
      check("b2b_pulses", 32'(fv_count), 32'd2);

      $display("[TB] stall with g_n high");
      do_reset(1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
         check("stall_sel", 32'(bus.sel), 32'd2);
         check("stall_strb", 32'(strb_seen), 32'hF);
         check("stall_fv", 32'(bus.frame_valid), 32'h0);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check("stall_done_y", 32'(bus.y), 32'h5);
      check("stall_done_fv", 32'(bus.frame_valid), 32'h1);
      check("stall_done_sel", 32'(bus.sel), 32'h0);

      $display("[TB] reset mid-frame");
      do_reset(1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, i == 0);
      check("pre_reset_y", 32'(bus.y), 32'hF);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, i == 0);
      do_reset(1);
      check("midreset_y", 32'(bus.y), 32'h0);
      check("midreset_sel", 32'(bus.sel), 32'h0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
         check("hunt_strb", 32'(strb_seen), 32'hE);
         check("hunt_sel", 32'(bus.sel), 32'h0);
         check("hunt_err", 32'(bus.err), 32'h0);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'(i == 2), 1'b1, i == 0);
      check("relock_y", 32'(bus.y), 32'h4);
      check("relock_fv", 32'(bus.frame_valid), 32'h1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(99) == 0) begin
            do_reset(1);
            checkOutput("rnd_reset");
         end
         g = ($urandom_range(7) == 0);
         v = ($urandom_range(3) != 0);
         d = W'($urandom);
         s = (model_sel() == 0) ? ($urandom_range(3) != 0) : ($urandom_range(9) == 0);
         exp_strb = model_strb(g, v);
         applyStimulus(g, d, v, s);
         check("rnd_strb", 32'(strb_seen), 32'(exp_strb));
         checkOutput("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
